message_scroller: RTL

MESSAGE_SCROLLER -- requirements
Module: message_scroller

---
 rtl/message_scroller_if.sv | 28 ++
 rtl/message_scroller.sv | 104 ++++++++++
 2 files changed

// File: rtl/message_scroller_if.sv
// Control, message-write and display-window signals of the message scroller.
// Latency: none; this is only a bundle of wires.
// Backpressure: none; every signal is a level or a single-cycle strobe.
interface message_scroller_if;
  logic       run;
  logic       dir;
  logic       step;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] char3;
  logic [3:0] char2;
  logic [3:0] char1;
  logic [3:0] char0;
  logic       adv;

  // Controller side: drives the controls and the writes, and watches the window.
  modport master (
    output run, dir, step, wr_en, wr_addr, wr_data,
    input  char3, char2, char1, char0, adv
  );

  // Scroller side.
  modport slave (
    input  run, dir, step, wr_en, wr_addr, wr_data,
    output char3, char2, char1, char0, adv
  );
endinterface

// File: rtl/message_scroller.sv
// Scrolls a 4-character window over a 16-entry message store. The optional manual step is enabled by MESSAGE_SCROLLER_MANUAL_STEP_EN.
// Latency: a pointer or message change at edge N shows on char3..char0 after edge N+1; adv is high in that same cycle.
// Backpressure: none; writes land every cycle, and advances come from the period counter or from a rising edge on step.
module message_scroller #(
  parameter int unsigned SCROLL_PERIOD = 25000000
) (
  input logic           clk,
  input logic           reset,
  message_scroller_if.slave bus
);

  // A counter wide enough to hold SCROLL_PERIOD-1 (SCROLL_PERIOD is at least 2).
  localparam int unsigned      CNT_W    = $clog2(SCROLL_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_PERIOD - 1);

  logic [3:0]       msg [16];
  logic [3:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic             adv_pend;   // pointer moved on the previous edge
  logic             terminal;   // the period counter wraps on this edge
  logic             manual_adv; // a rising edge on step is seen on this edge
  logic             advance;

`ifdef MESSAGE_SCROLLER_MANUAL_STEP_EN
  logic step_q;

  // Remember the previous step level so that holding step high gives only one advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= bus.step;
    end
  end

  assign manual_adv = bus.step & ~step_q;
`else
  // step is ignored in this build; the port stays for pin compatibility.
  logic step_unused;
  assign step_unused = bus.step;
  assign manual_adv  = 1'b0;
`endif

  // A terminal count and a manual step on the same edge merge into one advance.
  always_comb begin
    terminal = 1'b0;
    advance  = 1'b0;
    terminal = bus.run && (cnt == CNT_LAST);
    advance  = terminal || manual_adv;
  end

  // Period counter: it counts only while run is set, and a manual step starts a new period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= '0;
    end else if (bus.run) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pointer: dir is sampled only on an advance edge. 4-bit arithmetic wraps modulo 16.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= 4'd0;
      adv_pend <= 1'b0;
    end else begin
      adv_pend <= advance;
      if (advance) begin
        ptr <= bus.dir ? (ptr - 4'd1) : (ptr + 4'd1);
      end
    end
  end

  // Message store: it resets to the identity pattern, and a write lands on the strobe edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        msg[i] <= 4'(i);
      end
    end else if (bus.wr_en) begin
      msg[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Registered window: it follows the pointer and the store one edge later, and adv marks the first cycle of a new window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.char3 <= 4'd0;
      bus.char2 <= 4'd1;
      bus.char1 <= 4'd2;
      bus.char0 <= 4'd3;
      bus.adv   <= 1'b0;
    end else begin
      bus.char3 <= msg[ptr];
      bus.char2 <= msg[ptr + 4'd1];
      bus.char1 <= msg[ptr + 4'd2];
      bus.char0 <= msg[ptr + 4'd3];
      bus.adv   <= adv_pend;
    end
  end

endmodule
